// File: rtl/muldiv_ctrl_if.sv
// Bundle between the pipeline, the muldiv_ctrl sequencer and the Muldiv unit.
// The slave modport is the controller's view; the master modport is the view
// of whatever drives it (pipeline plus Muldiv unit, or a testbench).
interface muldiv_ctrl_if;
   // pipeline request side
   logic        req;
   logic [1:0]  op;
   logic [31:0] in_A;
   logic [31:0] in_B;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] result;
   logic        err;
   // Muldiv unit side
   logic        md_rst_n;
   logic        md_valid;
   logic        md_mode;
   logic [31:0] md_A;
   logic [31:0] md_B;
   logic        md_ready;
   logic [63:0] md_out;

   modport slave (
      input  req, op, in_A, in_B, flush, md_ready, md_out,
      output stall, done, result, err, md_rst_n, md_valid, md_mode, md_A, md_B
   );

   modport master (
      output req, op, in_A, in_B, flush, md_ready, md_out,
      input  stall, done, result, err, md_rst_n, md_valid, md_mode, md_A, md_B
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one multi-cycle multiply/divide through an external
// Muldiv unit (clear, launch, wait for ready), handles divide-by-zero locally,
// aborts on timeout and on pipeline flush.
// Optional feature macro: MULDIV_CACHE_EN adds a single-entry result cache
// that lets a repeated operand pair complete without touching the Muldiv unit.
module muldiv_ctrl #(
   parameter int TIMEOUT_CYCLES = 63
) (
   input  logic          clk,
   input  logic          rst_n,
   muldiv_ctrl_if.slave  bus
);

   // counter is at least 6 bits and always wide enough for TIMEOUT_CYCLES
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 6) ? $clog2(TIMEOUT_CYCLES + 1) : 6;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LAUNCH = 3'd2,
      S_WAIT   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // op[0] picks the high word: MULH -> product[63:32], REM -> {rem,quot}[63:32]
   function automatic logic [31:0] sel_word(input logic hi, input logic [63:0] d);
      return hi ? d[63:32] : d[31:0];
   endfunction

   // divide-by-zero answer: quotient all ones, remainder is the dividend
   function automatic logic [31:0] dz_word(input logic [1:0] op, input logic [31:0] a);
      return op[0] ? a : 32'hFFFF_FFFF;
   endfunction

   state_t            state_q, state_d;
   logic              stall_q, stall_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [31:0]       result_q, result_d;
   logic              md_rst_n_q, md_rst_n_d;
   logic              md_valid_q, md_valid_d;
   logic              md_mode_q, md_mode_d;
   logic [31:0]       md_A_q, md_A_d;
   logic [31:0]       md_B_q, md_B_d;
   logic              sel_hi_q, sel_hi_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              accept;
   logic              div_zero;
   logic              cache_hit;
   logic [63:0]       cache_word;
   logic              wait_ok;
   logic              wait_to;

   assign accept   = (state_q == S_IDLE) && bus.req && !bus.flush;
   assign div_zero = bus.op[1] && (bus.in_B == 32'd0);
   // flush has priority over a same-cycle md_ready or timeout
   assign wait_ok  = (state_q == S_WAIT) && !bus.flush && bus.md_ready;
   assign wait_to  = (state_q == S_WAIT) && !bus.flush && !bus.md_ready && (cnt_q == TO_LAST);

`ifdef MULDIV_CACHE_EN
   logic              cv_q;
   logic [31:0]       ca_q;
   logic [31:0]       cb_q;
   logic              cm_q;
   logic [63:0]       cd_q;

   assign cache_hit  = cv_q && (ca_q == bus.in_A) && (cb_q == bus.in_B) && (cm_q == bus.op[1]);
   assign cache_word = cd_q;

   // cache valid: set on a normal Muldiv completion, dropped on reset or timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cv_q <= 1'b0;
      end else if (wait_to) begin
         cv_q <= 1'b0;
      end else if (wait_ok) begin
         cv_q <= 1'b1;
      end
   end

   // cache payload: key and full 64-bit result of the last completed op
   always_ff @(posedge clk) begin
      if (wait_ok) begin
         ca_q <= md_A_q;
         cb_q <= md_B_q;
         cm_q <= md_mode_q;
         cd_q <= bus.md_out;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_word = 64'd0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (div_zero || cache_hit) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR:  state_d = bus.flush ? S_IDLE : S_LAUNCH;
         S_LAUNCH: state_d = bus.flush ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else if (wait_ok || wait_to) begin
               state_d = S_DONE;
            end
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // next values of the registered outputs and operand latches
   always_comb begin
      stall_d    = (state_d == S_CLEAR) || (state_d == S_LAUNCH) || (state_d == S_WAIT);
      md_rst_n_d = (state_d != S_CLEAR);
      md_valid_d = (state_d == S_LAUNCH);
      done_d     = (state_d == S_DONE);
      err_d      = wait_to;
      result_d   = result_q;
      md_mode_d  = md_mode_q;
      md_A_d     = md_A_q;
      md_B_d     = md_B_q;
      sel_hi_d   = sel_hi_q;
      cnt_d      = ((state_q == S_WAIT) && (state_d == S_WAIT)) ? cnt_q + 1'b1 : '0;
      if (accept) begin
         md_mode_d = bus.op[1];
         md_A_d    = bus.in_A;
         md_B_d    = bus.in_B;
         sel_hi_d  = bus.op[0];
         if (div_zero) begin
            result_d = dz_word(bus.op, bus.in_A);
         end else if (cache_hit) begin
            result_d = sel_word(bus.op[0], cache_word);
         end
      end
      if (wait_ok) begin
         result_d = sel_word(sel_hi_q, bus.md_out);
      end
      if (wait_to) begin
         result_d = 32'd0;
      end
   end

   // registered outputs, operand latches and WAIT counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         result_q   <= 32'd0;
         md_rst_n_q <= 1'b0;
         md_valid_q <= 1'b0;
         md_mode_q  <= 1'b0;
         md_A_q     <= 32'd0;
         md_B_q     <= 32'd0;
         sel_hi_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         stall_q    <= stall_d;
         done_q     <= done_d;
         err_q      <= err_d;
         result_q   <= result_d;
         md_rst_n_q <= md_rst_n_d;
         md_valid_q <= md_valid_d;
         md_mode_q  <= md_mode_d;
         md_A_q     <= md_A_d;
         md_B_q     <= md_B_d;
         sel_hi_q   <= sel_hi_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.stall    = stall_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.result   = result_q;
   assign bus.md_valid = md_valid_q;
   assign bus.md_mode  = md_mode_q;
   assign bus.md_A     = md_A_q;
   assign bus.md_B     = md_B_q;
   // a flush while busy must clear the Muldiv unit in the same cycle, so the
   // registered level is gated by flush (stall_q marks the busy states)
   assign bus.md_rst_n = md_rst_n_q && !(bus.flush && stall_q);

endmodule
